// File: rtl/des_decrypt_iter_pkg.sv
// Shared DES definitions: sizes, FSM encoding and the round-function tables
// used by both the encrypt pipeline and the iterative decrypt block.
package des_decrypt_iter_pkg;

  localparam int ROUNDS  = 16;
  localparam int KEY_W   = 48;
  localparam int BLOCK_W = 64;
  localparam int HALF_W  = BLOCK_W / 2;
  localparam int KEYS_W  = ROUNDS * KEY_W;
  localparam int CNT_W   = 4;

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Expansion table, DES bit numbering (1 = MSB of the 32-bit half).
  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  // Permutation applied to the S-box outputs.
  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // S-boxes S1..S8; each holds 64 nibbles, entry (row*16+col) first-digit-first.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Outer bits of the 6-bit group pick the row, inner four pick the column.
  function automatic logic [3:0] sbox_lookup(input int box, input logic [5:0] six);
    logic [5:0] idx;
    idx = {six[5], six[0], six[4:1]};
    return SBOX[box][255 - 4*idx -: 4];
  endfunction

endpackage

// File: rtl/des_decrypt_iter_round.sv
// One combinational DES Feistel round: L' = R, R' = L ^ f(R, K).
module round
  import des_decrypt_iter_pkg::*;
(
  input  logic [BLOCK_W-1:0] round_64_i,
  input  logic [KEY_W-1:0]   round_key,
  output logic [BLOCK_W-1:0] round_64_o
);

  logic [HALF_W-1:0] left_half;
  logic [HALF_W-1:0] right_half;
  logic [HALF_W-1:0] sbox_out;
  logic [HALF_W-1:0] f_out;
  logic [KEY_W-1:0]  expanded;
  logic [KEY_W-1:0]  mixed;

  assign left_half  = round_64_i[BLOCK_W-1:HALF_W];
  assign right_half = round_64_i[HALF_W-1:0];

  // Expand the right half, mix in the round key and substitute through S1..S8.
  always_comb begin
    expanded = '0;
    sbox_out = '0;
    for (int i = 0; i < KEY_W; i++) begin
      expanded[KEY_W-1-i] = right_half[HALF_W - E_TAB[i]];
    end
    mixed = expanded ^ round_key;
    for (int s = 0; s < 8; s++) begin
      sbox_out[HALF_W-1-4*s -: 4] = sbox_lookup(s, mixed[KEY_W-1-6*s -: 6]);
    end
  end

  // Final P permutation of the substituted word gives f(R, K).
  always_comb begin
    f_out = '0;
    for (int i = 0; i < HALF_W; i++) begin
      f_out[HALF_W-1-i] = sbox_out[HALF_W - P_TAB[i]];
    end
  end

  assign round_64_o = {right_half, left_half ^ f_out};

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryptor: one shared Feistel round reused for 16 cycles,
// keys taken K16 first from a static key register via a counter-indexed mux.
module des_decrypt_iter
  import des_decrypt_iter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [BLOCK_W-1:0] cipher_ip_in,
  input  logic [KEYS_W-1:0]  round_keys,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] plain_final_perm
);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   round_cnt;
  logic [BLOCK_W-1:0] data_q;
  logic [BLOCK_W-1:0] round_out;
  logic [KEYS_W-1:0]  keys_q;
  logic [KEY_W-1:0]   cur_key;
  logic               accept;
  logic               last_round;

  assign accept     = in_valid && (state_q == ST_IDLE);
  assign last_round = (round_cnt == LAST_ROUND);

  // Counter value n selects K(16-n), which sits at bits [48n+47:48n].
  assign cur_key = keys_q[KEY_W*round_cnt +: KEY_W];

  round u_round (
    .round_64_i (data_q),
    .round_key  (cur_key),
    .round_64_o (round_out)
  );

  // FSM state register; reset wins over any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept -> 16 rounds -> hold until the result is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)   state_d = ST_RUN;
      ST_RUN:  if (last_round) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode the state; the data output is always the swapped register.
  always_comb begin
    in_ready         = (state_q == ST_IDLE);
    out_valid        = (state_q == ST_DONE);
    plain_final_perm = {data_q[HALF_W-1:0], data_q[BLOCK_W-1:HALF_W]};
  end

  // Datapath: capture block and keys on accept, then one round per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      keys_q    <= '0;
      round_cnt <= '0;
    end else if (accept) begin
      data_q    <= cipher_ip_in;
      keys_q    <= round_keys;
      round_cnt <= '0;
    end else if (state_q == ST_RUN) begin
      data_q <= round_out;
      if (!last_round) begin
        round_cnt <= round_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Self-checking bench for des_decrypt_iter against a textbook DES model.
module tb_des_decrypt_iter;

  logic         clk;
  logic         rst;
  logic [63:0]  cipher_ip_in;
  logic [767:0] round_keys;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  plain_final_perm;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [63:0] key;
    logic [63:0] cipher;
    logic [63:0] plain;
  } vec_t;

  vec_t vecs [5];

  des_decrypt_iter dut (
    .clk              (clk),
    .rst              (rst),
    .cipher_ip_in     (cipher_ip_in),
    .round_keys       (round_keys),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .plain_final_perm (plain_final_perm)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
  };
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25
  };
  localparam int E_T [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1
  };
  localparam int P_T [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
  };
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // One 16-nibble row per entry: S1 rows 0..3, then S2 rows 0..3, and so on.
  localparam logic [63:0] SBOX_ROWS [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  function automatic logic [63:0] permute_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64 - IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] permute_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64 - FP_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s_out;
    logic [31:0] res;
    logic [5:0]  six;
    int row;
    int col;
    for (int i = 0; i < 48; i++) x[47-i] = r[32 - E_T[i]];
    x = x ^ k;
    for (int s = 0; s < 8; s++) begin
      six = x[47-6*s -: 6];
      row = int'({six[5], six[0]});
      col = int'(six[4:1]);
      s_out[31-4*s -: 4] = SBOX_ROWS[4*s + row][63 - 4*col -: 4];
    end
    for (int i = 0; i < 32; i++) res[31-i] = s_out[32 - P_T[i]];
    return res;
  endfunction

  // Full key schedule, packed K1 in the top 48 bits down to K16 at the bottom.
  function automatic logic [767:0] key_sched(input logic [63:0] key);
    logic [55:0]  cd;
    logic [27:0]  c;
    logic [27:0]  d;
    logic [47:0]  k;
    logic [767:0] all_keys;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64 - PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFT_T[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[47-i] = cd[56 - PC2_T[i]];
      all_keys[767 - 48*r -: 48] = k;
    end
    return all_keys;
  endfunction

  // Subkey K<idx> for idx in 1..16.
  function automatic logic [47:0] subkey(input logic [767:0] ks, input int idx);
    return ks[767 - 48*(idx-1) -: 48];
  endfunction

  // Textbook DES: encrypt uses K1..K16, decrypt uses K16..K1.
  function automatic logic [63:0] des_crypt(input logic [63:0] key, input logic [63:0] blk,
                                            input bit decrypt);
    logic [767:0] ks;
    logic [63:0]  lr;
    logic [31:0]  l;
    logic [31:0]  r;
    logic [31:0]  t;
    ks = key_sched(key);
    lr = permute_ip(blk);
    l = lr[63:32];
    r = lr[31:0];
    for (int n = 1; n <= 16; n++) begin
      t = r;
      r = l ^ f_model(r, subkey(ks, decrypt ? 17 - n : n));
      l = t;
    end
    return permute_fp({r, l});
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [767:0] rand768();
    logic [767:0] v;
    for (int i = 0; i < 24; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic applyStimulus(input logic v, input logic [63:0] c, input logic [767:0] k,
                               input logic ordy);
    in_valid     = v;
    cipher_ip_in = c;
    round_keys   = k;
    out_ready    = ordy;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Full transaction with out_ready high; inputs are scrambled while running.
  task automatic run_block(input logic [63:0] key, input logic [63:0] ct,
                           input logic [63:0] pt, input string name);
    int budget;
    budget = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    applyStimulus(1'b1, permute_ip(ct), key_sched(key), 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, rand64(), rand768(), 1'b1);
    budget = 0;
    while (!out_valid && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    checkOutput({name, "_valid"}, {63'd0, out_valid}, 64'd1);
    checkOutput(name, permute_fp(plain_final_perm), pt);
    @(negedge clk);
  endtask

  // Main test sequence.
  initial begin
    logic [63:0] key;
    logic [63:0] pt;
    logic [63:0] ct;
    int          budget;
    int          seen;
    int          accepts [$];

    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_data", plain_final_perm, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = '{key: 64'h133457799BBCDFF1, cipher: 64'h85E813540F0AB405,
                plain: 64'h0123456789ABCDEF};
    vecs[1] = '{key: 64'h0E329232EA6D0D73, cipher: 64'h0000000000000000,
                plain: 64'h8787878787878787};
    vecs[2] = '{key: 64'h0, cipher: 64'h8CA64DE9C1B123A7, plain: 64'h0};
    vecs[3] = '{key: 64'h0, cipher: 64'h0, plain: des_crypt(64'h0, 64'h0, 1'b1)};
    key = rand64();
    pt  = rand64();
    vecs[4] = '{key: key, cipher: des_crypt(key, pt, 1'b0), plain: pt};
    for (int i = 0; i < 5; i++) begin
      run_block(vecs[i].key, vecs[i].cipher, vecs[i].plain, $sformatf("table_vec%0d", i));
    end

    // Latency: accept at edge 0, result visible after edge 16, ready after 17.
    key = rand64();
    pt  = rand64();
    ct  = des_crypt(key, pt, 1'b0);
    applyStimulus(1'b1, permute_ip(ct), key_sched(key), 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, rand64(), rand768(), 1'b1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checkOutput($sformatf("latency_valid_e%0d", k), {63'd0, out_valid}, {63'd0, k == 16});
    end
    checkOutput("latency_data", permute_fp(plain_final_perm), pt);
    checkOutput("latency_busy", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("latency_ready_e17", {63'd0, in_ready}, 64'd1);
    checkOutput("latency_valid_e17", {63'd0, out_valid}, 64'd0);

    // Back-pressure: hold out_ready low for 50 cycles in DONE.
    key = rand64();
    pt  = rand64();
    ct  = des_crypt(key, pt, 1'b0);
    applyStimulus(1'b1, permute_ip(ct), key_sched(key), 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, rand64(), rand768(), 1'b0);
    budget = 0;
    while (!out_valid && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    for (int c = 0; c < 50; c++) begin
      checkOutput("bp_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("bp_data", permute_fp(plain_final_perm), pt);
      checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    applyStimulus(1'b0, rand64(), rand768(), 1'b1);
    @(negedge clk);
    checkOutput("bp_after_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("bp_after_ready", {63'd0, in_ready}, 64'd1);

    // Reset at round n=7 aborts the block; a new block then decrypts.
    key = rand64();
    pt  = rand64();
    ct  = des_crypt(key, pt, 1'b0);
    applyStimulus(1'b1, permute_ip(ct), key_sched(key), 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("abort_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("abort_data", plain_final_perm, 64'd0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    checkOutput("abort_no_output", 64'(seen), 64'd0);
    key = rand64();
    pt  = rand64();
    run_block(key, des_crypt(key, pt, 1'b0), pt, "after_abort");

    // Streaming: in_valid held high gives exactly one accept per 18 cycles.
    key = rand64();
    pt  = rand64();
    ct  = des_crypt(key, pt, 1'b0);
    applyStimulus(1'b1, permute_ip(ct), key_sched(key), 1'b1);
    for (int c = 0; c < 110; c++) begin
      if (in_valid && in_ready) accepts.push_back(c);
      if (out_valid) checkOutput("stream_data", permute_fp(plain_final_perm), pt);
      @(negedge clk);
    end
    checkOutput("stream_accepts", 64'(accepts.size()), 64'd7);
    for (int i = 1; i < accepts.size(); i++) begin
      checkOutput("stream_interval", 64'(accepts[i] - accepts[i-1]), 64'd18);
    end
    do_reset();

    // Random round trips through the model's encryptor.
    for (int i = 0; i < 1000; i++) begin
      key = rand64();
      pt  = rand64();
      run_block(key, des_crypt(key, pt, 1'b0), pt, "roundtrip");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
